// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one stb/ack FP32 adder among NUM_REQ requesters.
// Subtraction is issued as an add with operand B's sign bit flipped.
module fp_addsub_sched #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_op,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [31:0]            rsp_z,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    output logic                   add_a_stb,
    output logic                   add_b_stb,
    input  logic                   add_a_ack,
    input  logic                   add_b_ack,
    input  logic [31:0]            add_z,
    input  logic                   add_z_stb,
    output logic                   add_z_ack,
    output logic                   busy,
    output logic [15:0]            op_count
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_found;
    logic [IDW:0]   cand;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           a_done;
    logic           b_done;

    // Scan rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ; one extra bit keeps the wrap exact for non-power-of-two counts.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    assign sel_a  = req_a[32*gnt_idx +: 32];
    assign sel_b  = req_b[32*gnt_idx +: 32];
    assign a_done = !add_a_stb || add_a_ack;
    assign b_done = !add_b_stb || add_b_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found)        state_nxt = SEND;
            SEND:    if (a_done && b_done) state_nxt = WAIT_Z;
            WAIT_Z:  if (add_z_stb)        state_nxt = RESP;
            RESP:    if (rsp_ready)        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= IDW'(NUM_REQ - 1);
            gnt_id    <= '0;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b0;
            busy      <= 1'b0;
            op_count  <= '0;
        end else begin
            req_ready <= '0;
            add_z_ack <= 1'b0;
            busy      <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        req_ready <= NUM_REQ'(1) << gnt_idx;
                        add_a     <= sel_a;
                        add_b     <= {sel_b[31] ^ req_op[gnt_idx], sel_b[30:0]};
                        gnt_id    <= gnt_idx;
                        rr_ptr    <= gnt_idx;
                        add_a_stb <= 1'b1;
                        add_b_stb <= 1'b1;
                    end
                end
                SEND: begin
                    // Each strobe retires independently as soon as its own ack is seen.
                    if (add_a_ack) add_a_stb <= 1'b0;
                    if (add_b_ack) add_b_stb <= 1'b0;
                end
                WAIT_Z: begin
                    if (add_z_stb) begin
                        rsp_z     <= add_z;
                        rsp_id    <= gnt_id;
                        add_z_ack <= 1'b1;
                        rsp_valid <= 1'b1;
                        op_count  <= op_count + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
